// File: rtl/rgb_led_sequencer_if.sv
// rtl/rgb_led_sequencer_if.sv - button inputs and LED/mode/level outputs of the RGB LED sequencer
interface rgb_led_sequencer_if;
  logic       push_button0;
  logic       push_button1;
  logic       led_red;
  logic       led_green;
  logic       led_blue;
  logic [2:0] mode;
  logic [2:0] level;

  // Button source / LED sink side
  modport master (
    output push_button0, push_button1,
    input  led_red, led_green, led_blue, mode, level
  );

  // Sequencer side
  modport slave (
    input  push_button0, push_button1,
    output led_red, led_green, led_blue, mode, level
  );
endinterface

// File: rtl/rgb_led_sequencer.sv
// rtl/rgb_led_sequencer.sv - button-driven RGB colour mode sequencer with blink and optional PWM dimming (RGB_LED_SEQUENCER_PWM_EN)
module rgb_led_sequencer #(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 24
) (
  input  logic               clock,
  input  logic               reset_n,
  rgb_led_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_RED   = 3'd1,
    M_GREEN = 3'd2,
    M_BLUE  = 3'd3,
    M_WHITE = 3'd4,
    M_BLINK = 3'd5
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic                  prev0_q, prev0_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]            led_q, led_d;
  logic                  edge0;
  logic                  pwm_on;
  logic                  blink_on;
  logic [2:0]            colour;

`ifdef RGB_LED_SEQUENCER_PWM_EN
  logic                prev1_q, prev1_d;
  logic [2:0]          level_q, level_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                edge1;

  // Brightness stepping on push_button1 edges and the free-running PWM compare
  always_comb begin
    edge1     = io.push_button1 & ~prev1_q;
    prev1_d   = io.push_button1;
    level_d   = edge1 ? level_q - 3'd1 : level_q;
    pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    pwm_on    = (pwm_cnt_q[PWM_BITS-1 -: 3] <= level_q);
  end

  // Brightness state; prev1 resets high so a button held through reset gives no edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev1_q   <= 1'b1;
      level_q   <= 3'd7;
      pwm_cnt_q <= '0;
    end else begin
      prev1_q   <= prev1_d;
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign io.level = level_q;
`else
  logic unused_push_button1;

  assign unused_push_button1 = io.push_button1;
  assign pwm_on              = 1'b1;
  assign io.level            = 3'd7;
`endif

  // Mode advance on push_button0 edges, blink counter and gated colour decode
  always_comb begin
    edge0       = io.push_button0 & ~prev0_q;
    prev0_d     = io.push_button0;
    blink_cnt_d = blink_cnt_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
    blink_on    = blink_cnt_q[BLINK_BITS-1];
    mode_d      = mode_q;
    colour      = 3'b000;
    case (mode_q)
      M_OFF:   begin colour = 3'b000;        if (edge0) mode_d = M_RED;   end
      M_RED:   begin colour = 3'b100;        if (edge0) mode_d = M_GREEN; end
      M_GREEN: begin colour = 3'b010;        if (edge0) mode_d = M_BLUE;  end
      M_BLUE:  begin colour = 3'b001;        if (edge0) mode_d = M_WHITE; end
      M_WHITE: begin colour = 3'b111;        if (edge0) mode_d = M_BLINK; end
      M_BLINK: begin colour = {3{blink_on}}; if (edge0) mode_d = M_OFF;   end
      default: begin colour = 3'b000;        mode_d = M_OFF;              end
    endcase
    led_d = pwm_on ? colour : 3'b000;
  end

  // Mode state, blink counter and registered LED enables
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q      <= M_OFF;
      prev0_q     <= 1'b1;
      blink_cnt_q <= '0;
      led_q       <= 3'b000;
    end else begin
      mode_q      <= mode_d;
      prev0_q     <= prev0_d;
      blink_cnt_q <= blink_cnt_d;
      led_q       <= led_d;
    end
  end

  assign io.mode      = mode_q;
  assign io.led_red   = led_q[2];
  assign io.led_green = led_q[1];
  assign io.led_blue  = led_q[0];

endmodule
